// File: rtl/csr_counter_bank_if.sv
// CSR read/write bus between the CSR pipeline and the counter bank.
// master = CSR pipeline (issues reads and write commits), slave = counter bank.
interface csr_counter_bank_if #(
    parameter int XLEN = 32
);
    logic            readEnable;
    logic [11:0]     readAddr;
    logic [1:0]      readPrivilege;
    logic            readHit;
    logic [XLEN-1:0] readValue;
    logic            readIllegal;
    logic            writeEnable;
    logic [11:0]     writeAddr;
    logic [XLEN-1:0] writeValue;

    modport master (
        output readEnable, readAddr, readPrivilege, writeEnable, writeAddr, writeValue,
        input  readHit, readValue, readIllegal
    );

    modport slave (
        input  readEnable, readAddr, readPrivilege, writeEnable, writeAddr, writeValue,
        output readHit, readValue, readIllegal
    );
endinterface

// File: rtl/csr_counter_bank.sv
// Machine/user performance counters (mcycle, minstret, mhpmcounterN) with
// inhibit and counter-enable registers. One 64-bit lane per implemented index.

// One 64-bit counter: a write (either half) wins over the increment and
// never produces an overflow pulse.
module csr_counter_lane #(
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inhibit,
    input  logic [INC_W-1:0] inc,
    input  logic             wrLo,
    input  logic             wrHi,
    input  logic [63:0]      wrData,
    output logic [63:0]      count,
    output logic             ovf
);
    logic [64:0] sum;
    assign sum = {1'b0, count} + 65'(inc);

    // Counter state: write replaces selected halves, otherwise count unless inhibited.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (wrLo || wrHi) begin
            count <= {wrHi ? wrData[63:32] : count[63:32],
                      wrLo ? wrData[31:0]  : count[31:0]};
            ovf   <= 1'b0;
        end else if (!inhibit) begin
            count <= sum[63:0];
            ovf   <= sum[64];
        end else begin
            ovf   <= 1'b0;
        end
    end
endmodule

module csr_counter_bank #(
    parameter int XLEN         = 32,
    parameter int NUM_HPM      = 4,
    parameter int RETIRE_WIDTH = 2,
    localparam int HPM_W       = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    csr_counter_bank_if.slave       bus,
    input  logic [RETIRE_WIDTH-1:0] retireCount,
    input  logic [HPM_W-1:0]        hpmEvent,
    output logic [31:0]             overflow
);
    localparam bit          RV32  = (XLEN == 32);
    localparam logic [1:0]  PRV_M = 2'b11;
    localparam logic [1:0]  PRV_U = 2'b00;
    // Bits 0 (CY), 2 (IR) and the implemented HPM indices; bit 1 (TM) stays 0.
    localparam logic [31:0] WMASK = 32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

    logic [31:0]       mcountinhibit, mcounteren, scounteren;
    logic [31:0][63:0] cnt;

    // Write decode: only the machine counter ranges are writable.
    logic [4:0]  wIdx;
    logic        wMachLo, wMachHi;
    logic [63:0] wrData;
    assign wIdx    = bus.writeAddr[4:0];
    assign wMachLo = bus.writeEnable && (bus.writeAddr[11:5] == 7'h58);
    assign wMachHi = bus.writeEnable && RV32 && (bus.writeAddr[11:5] == 7'h5C);

    if (XLEN == 64) begin : g_wd64
        assign wrData = 64'(bus.writeValue);
    end else begin : g_wd32
        // Same word on both halves; the lane picks the half being written.
        assign wrData = {bus.writeValue, bus.writeValue};
    end

    for (genvar n = 0; n < 32; n++) begin : g_ctr
        if (n == 0 || n == 2 || (n >= 3 && n < 3 + NUM_HPM)) begin : g_impl
            localparam int IW = (n == 2) ? RETIRE_WIDTH : 1;
            logic [IW-1:0] inc;
            logic          laneWrLo, laneWrHi;
            if (n == 0) begin : g_cyc
                assign inc = 1'b1;
            end else if (n == 2) begin : g_ret
                assign inc = retireCount;
            end else begin : g_hpm
                assign inc = hpmEvent[n-3];
            end
            assign laneWrLo = wMachLo && (wIdx == 5'(n));
            assign laneWrHi = (RV32 ? wMachHi : wMachLo) && (wIdx == 5'(n));
            csr_counter_lane #(.INC_W(IW)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .inhibit(mcountinhibit[n]),
                .inc    (inc),
                .wrLo   (laneWrLo),
                .wrHi   (laneWrHi),
                .wrData (wrData),
                .count  (cnt[n]),
                .ovf    (overflow[n])
            );
        end else begin : g_none
            assign cnt[n]      = 64'd0;
            assign overflow[n] = 1'b0;
        end
    end

    // Control registers; stored pre-masked so reads need no further masking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcountinhibit <= '0;
            mcounteren    <= '0;
            scounteren    <= '0;
        end else if (bus.writeEnable) begin
            case (bus.writeAddr)
                12'h320: mcountinhibit <= bus.writeValue[31:0] & WMASK;
                12'h306: mcounteren    <= bus.writeValue[31:0] & WMASK;
                12'h106: scounteren    <= bus.writeValue[31:0] & WMASK;
                default: ;
            endcase
        end
    end

    // Read decode: high-half ranges exist only on RV32.
    logic [4:0]  rIdx;
    logic        rMach, rUser, rHi, rHit, rBad;
    logic [63:0] cntSel;
    logic [XLEN-1:0] rdVal;
    assign rIdx   = bus.readAddr[4:0];
    assign rMach  = (bus.readAddr[11:5] == 7'h58) || (RV32 && bus.readAddr[11:5] == 7'h5C);
    assign rUser  = (bus.readAddr[11:5] == 7'h60) || (RV32 && bus.readAddr[11:5] == 7'h64);
    assign rHi    = RV32 && (bus.readAddr[11:5] == 7'h5C || bus.readAddr[11:5] == 7'h64);
    assign cntSel = cnt[rIdx];
    assign rHit   = rMach || rUser || bus.readAddr == 12'h320 ||
                    bus.readAddr == 12'h306 || bus.readAddr == 12'h106;

    // Read mux and privilege check; value is driven even on an illegal access.
    always_comb begin
        rdVal = '0;
        rBad  = 1'b0;
        if (rMach || rUser) begin
            rdVal = rHi ? XLEN'(cntSel[63:32]) : cntSel[XLEN-1:0];
        end else if (bus.readAddr == 12'h320) begin
            rdVal = XLEN'(mcountinhibit);
        end else if (bus.readAddr == 12'h306) begin
            rdVal = XLEN'(mcounteren);
        end else if (bus.readAddr == 12'h106) begin
            rdVal = XLEN'(scounteren);
        end
        if (rMach || bus.readAddr == 12'h320 || bus.readAddr == 12'h306)
            rBad = (bus.readPrivilege != PRV_M);
        else if (bus.readAddr == 12'h106)
            rBad = (bus.readPrivilege == PRV_U);
        else if (rUser)
            rBad = (bus.readPrivilege != PRV_M && !mcounteren[rIdx]) ||
                   (bus.readPrivilege == PRV_U && !scounteren[rIdx]);
    end

    assign bus.readHit     = rHit;
    assign bus.readValue   = rdVal;
    assign bus.readIllegal = bus.readEnable && rHit && rBad;
endmodule

// File: tb/tb_csr_counter_bank.sv
// Bench for csr_counter_bank (RV32, 4 HPM counters): architectural model
// checked every cycle, plus directed reads against hand-computed values.
module tb_csr_counter_bank;
    localparam int XLEN = 32;
    localparam int NUM_HPM = 4;
    localparam int RW = 2;
    localparam logic [31:0] MASK = 32'h7D;   // bits 0, 2, 3..6

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] retireCount;
    logic [3:0]    hpmEvent;
    logic [31:0]   overflow;

    csr_counter_bank_if #(.XLEN(XLEN)) bus();

    csr_counter_bank #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .RETIRE_WIDTH(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .retireCount(retireCount),
        .hpmEvent   (hpmEvent),
        .overflow   (overflow)
    );

    initial forever #5 clk = ~clk;

    int nCmp = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- architectural model ----------------
    logic [63:0] mc [32];
    logic [31:0] inh, mcen, scen, ovfM;

    function automatic bit impl(int n);
        return n == 0 || n == 2 || (n >= 3 && n < 3 + NUM_HPM);
    endfunction

    function automatic logic [63:0] incOf(int n);
        if (n == 0) return 64'd1;
        if (n == 2) return 64'(retireCount);
        return 64'(hpmEvent[n-3]);
    endfunction

    function automatic bit written(int n);
        return bus.writeEnable && (bus.writeAddr == 12'(12'hB00 + n) ||
                                   bus.writeAddr == 12'(12'hB80 + n));
    endfunction

    function automatic logic [63:0] nextCnt(int n);
        if (!impl(n)) return 64'd0;
        if (bus.writeEnable && bus.writeAddr == 12'(12'hB00 + n))
            return {mc[n][63:32], bus.writeValue};
        if (bus.writeEnable && bus.writeAddr == 12'(12'hB80 + n))
            return {bus.writeValue, mc[n][31:0]};
        if (inh[n]) return mc[n];
        return mc[n] + incOf(n);
    endfunction

    function automatic logic wrapNow(int n);
        logic [63:0] s;
        s = mc[n] + incOf(n);
        return impl(n) && !written(n) && !inh[n] && (s < mc[n]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 32; n++) mc[n] <= 64'd0;
            inh  <= '0;
            mcen <= '0;
            scen <= '0;
            ovfM <= '0;
        end else begin
            for (int n = 0; n < 32; n++) begin
                mc[n]   <= nextCnt(n);
                ovfM[n] <= wrapNow(n);
            end
            if (bus.writeEnable && bus.writeAddr == 12'h320) inh  <= bus.writeValue & MASK;
            if (bus.writeEnable && bus.writeAddr == 12'h306) mcen <= bus.writeValue & MASK;
            if (bus.writeEnable && bus.writeAddr == 12'h106) scen <= bus.writeValue & MASK;
        end
    end

    function automatic void expRead(output logic hit, output logic [31:0] val, output logic ill);
        logic [11:0] a;
        logic [1:0]  p;
        int          n;
        a = bus.readAddr;
        p = bus.readPrivilege;
        n = int'(a[4:0]);
        hit = 1'b0; val = '0; ill = 1'b0;
        if (a >= 12'hB00 && a <= 12'hB1F) begin
            hit = 1'b1; val = mc[n][31:0];  ill = (p != 2'd3);
        end else if (a >= 12'hB80 && a <= 12'hB9F) begin
            hit = 1'b1; val = mc[n][63:32]; ill = (p != 2'd3);
        end else if ((a >= 12'hC00 && a <= 12'hC1F) || (a >= 12'hC80 && a <= 12'hC9F)) begin
            hit = 1'b1;
            val = (a >= 12'hC80) ? mc[n][63:32] : mc[n][31:0];
            ill = (p != 2'd3 && !mcen[n]) || (p == 2'd0 && !scen[n]);
        end else if (a == 12'h320) begin
            hit = 1'b1; val = inh;  ill = (p != 2'd3);
        end else if (a == 12'h306) begin
            hit = 1'b1; val = mcen; ill = (p != 2'd3);
        end else if (a == 12'h106) begin
            hit = 1'b1; val = scen; ill = (p == 2'd0);
        end
        ill = ill && bus.readEnable;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        logic        h, il;
        logic [31:0] v;
        forever begin
            @(negedge clk);
            expRead(h, v, il);
            check("cyc readHit", 64'(bus.readHit), 64'(h));
            check("cyc readValue", 64'(bus.readValue), 64'(v));
            check("cyc readIllegal", 64'(bus.readIllegal), 64'(il));
            check("cyc overflow", 64'(overflow), 64'(ovfM));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic readAt(input logic [11:0] a);
        bus.readAddr = a;
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.writeEnable = 1'b1;
        bus.writeAddr   = a;
        bus.writeValue  = d;
    endtask

    initial begin
        rst = 1'b0;
        retireCount = '0;
        hpmEvent = '0;
        bus.readEnable = 1'b0;
        bus.readAddr = 12'h000;
        bus.readPrivilege = 2'd3;
        bus.writeEnable = 1'b0;
        bus.writeAddr = 12'h000;
        bus.writeValue = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        bus.readEnable = 1'b1;
        readAt(12'hB00); check("reset mcycle", 64'(bus.readValue), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        readAt(12'h320); check("reset inhibit", 64'(bus.readValue), 64'd0);

        // 10 cycles after release, one retire per cycle
        rst = 1'b0;
        retireCount = 2'd1;
        bus.readAddr = 12'hB00;
        repeat (10) @(posedge clk);
        #2;
        readAt(12'hB00); check("mcycle after 10", 64'(bus.readValue), 64'd10);
        check("model mcycle after 10", mc[0], 64'd10);
        readAt(12'hB02); check("minstret after 10", 64'(bus.readValue), 64'd10);
        retireCount = 2'd0;

        // RV32 halves: carry from low into high, no overflow pulse
        wr(12'hB80, 32'h0);
        tick();
        wr(12'hB00, 32'hFFFF_FFFE);
        tick();
        bus.writeEnable = 1'b0;
        repeat (3) tick();
        readAt(12'hB00); check("mcycle lo after carry", 64'(bus.readValue), 64'h1);
        readAt(12'hB80); check("mcycle hi after carry", 64'(bus.readValue), 64'h1);
        check("no ovf on carry", 64'(overflow), 64'd0);

        // 64-bit wrap
        wr(12'hB80, 32'hFFFF_FFFF);
        tick();
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        bus.writeEnable = 1'b0;
        tick();
        readAt(12'hB00); check("mcycle wrapped lo", 64'(bus.readValue), 64'd0);
        check("ovf pulse", 64'(overflow), 64'h1);
        readAt(12'hB80); check("mcycle wrapped hi", 64'(bus.readValue), 64'd0);
        tick();
        check("ovf one cycle", 64'(overflow), 64'd0);
        readAt(12'hB00); check("mcycle after wrap", 64'(bus.readValue), 64'd1);

        // inhibit CY and IR
        wr(12'h320, 32'h5);
        retireCount = 2'd3;
        tick();
        bus.writeEnable = 1'b0;
        readAt(12'h320); check("inhibit value", 64'(bus.readValue), 64'h5);
        readAt(12'hB00); check("mcycle at inhibit", 64'(bus.readValue), 64'd2);
        readAt(12'hB02); check("minstret at inhibit", 64'(bus.readValue), 64'd13);
        repeat (4) tick();
        readAt(12'hB00); check("mcycle inhibited", 64'(bus.readValue), 64'd2);
        readAt(12'hB02); check("minstret inhibited", 64'(bus.readValue), 64'd13);
        wr(12'h320, 32'h0);
        tick();
        bus.writeEnable = 1'b0;
        readAt(12'hB02); check("minstret last inhibited", 64'(bus.readValue), 64'd13);
        repeat (2) tick();
        readAt(12'hB02); check("minstret +3/cycle", 64'(bus.readValue), 64'd19);
        readAt(12'hB00); check("mcycle resumed", 64'(bus.readValue), 64'd4);
        retireCount = 2'd0;

        // user-mode access rules
        wr(12'h306, 32'h1);
        tick();
        bus.writeEnable = 1'b0;
        bus.readPrivilege = 2'd0;
        readAt(12'hC00); check("U C00 scen=0 illegal", 64'(bus.readIllegal), 64'd1);
        wr(12'h106, 32'h1);
        tick();
        bus.writeEnable = 1'b0;
        readAt(12'hC00); check("U C00 legal", 64'(bus.readIllegal), 64'd0);
        check("U C00 value", 64'(bus.readValue), 64'd6);
        readAt(12'hB00); check("U B00 illegal", 64'(bus.readIllegal), 64'd1);
        bus.readPrivilege = 2'd1;
        readAt(12'h106); check("S 106 legal", 64'(bus.readIllegal), 64'd0);
        bus.readPrivilege = 2'd0;
        readAt(12'h106); check("U 106 illegal", 64'(bus.readIllegal), 64'd1);
        bus.readEnable = 1'b0;
        #1 check("no illegal without enable", 64'(bus.readIllegal), 64'd0);
        bus.readEnable = 1'b1;
        bus.readPrivilege = 2'd3;
        wr(12'h306, 32'hFFFF_FFFF);
        tick();
        bus.writeEnable = 1'b0;
        readAt(12'h306); check("mcounteren mask", 64'(bus.readValue), 64'h7D);

        // HPM events
        hpmEvent = 4'b1010;
        repeat (5) tick();
        hpmEvent = 4'b0000;
        readAt(12'hB04); check("hpm4", 64'(bus.readValue), 64'd5);
        readAt(12'hB06); check("hpm6", 64'(bus.readValue), 64'd5);
        readAt(12'hB03); check("hpm3", 64'(bus.readValue), 64'd0);
        readAt(12'hB05); check("hpm5", 64'(bus.readValue), 64'd0);
        tick();
        readAt(12'hB07); check("B07 hit", 64'(bus.readHit), 64'd1);
        check("B07 value", 64'(bus.readValue), 64'd0);
        readAt(12'hC04); check("C04 shadow", 64'(bus.readValue), 64'd5);
        readAt(12'h300); check("300 no hit", 64'(bus.readHit), 64'd0);
        wr(12'hC04, 32'h1234);
        tick();
        wr(12'hB07, 32'h55);
        tick();
        bus.writeEnable = 1'b0;
        readAt(12'hB04); check("C04 write ignored", 64'(bus.readValue), 64'd5);
        readAt(12'hB07); check("B07 write ignored", 64'(bus.readValue), 64'd0);

        // asynchronous reset mid-count
        tick();
        rst = 1'b1;
        readAt(12'hB00); check("async reset mcycle", 64'(bus.readValue), 64'd0);
        readAt(12'hB04); check("async reset hpm4", 64'(bus.readValue), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        readAt(12'hB00); check("first count after reset", 64'(bus.readValue), 64'd1);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
